// File: rtl/shift_reg_seq.sv
// shift_reg_seq: command sequencer for the 4-bit shift_reg datapath.
// Accepts LOAD / SHR n / SHL n / LOAD_SHR n commands and generates the
// per-cycle cntrl codes. It returns the final register contents with a
// one-cycle response pulse.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE and while reset is released.
// cmd_* is ignored at every other edge and nothing is queued. rsp_valid is
// a single-cycle pulse with no back-pressure.
module shift_reg_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       sr_cntrl,
  output logic [WIDTH-1:0] sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [1:0] CN_HOLD  = 2'b00;
  localparam logic [1:0] CN_RIGHT = 2'b01;
  localparam logic [1:0] CN_LEFT  = 2'b10;
  localparam logic [1:0] CN_LOAD  = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;

  // Sequencing FSM: latches the command on accept, counts shifts, and captures the response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      data_q    <= '0;
      rem_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rem_q  <= cmd_count;
            if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR)
              state <= S_LOAD;
            else if (cmd_count != '0)
              state <= S_SHIFT;
            else
              state <= S_DONE;
          end
        end
        S_LOAD: begin
          // A plain LOAD, or a load-then-shift of zero, has nothing left to shift.
          if (op_q == OP_LOAD || rem_q == '0)
            state <= S_DONE;
          else
            state <= S_SHIFT;
        end
        S_SHIFT: begin
          // SHIFT is only entered with rem_q != 0, so this never wraps.
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1))
            state <= S_DONE;
        end
        S_DONE: begin
          rsp_data  <= sr_q;
          rsp_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the state register and latched opcode only.
  always_comb begin
    sr_cntrl = CN_HOLD;
    case (state)
      S_LOAD:  sr_cntrl = CN_LOAD;
      S_SHIFT: sr_cntrl = (op_q == OP_SHL) ? CN_LEFT : CN_RIGHT;
      default: sr_cntrl = CN_HOLD;
    endcase
  end

  assign sr_d      = data_q;
  assign busy      = (state != S_IDLE);
  assign cmd_ready = (state == S_IDLE) && reset;
  assign dbg_state = state;

  // OP_SHR is decoded implicitly as the non-SHL shift direction.
  localparam logic [1:0] OP_SHR_UNUSED = OP_SHR;

endmodule
